// File: rtl/iob_eth_axi_mem_slv_pkg.sv
// Shared AXI burst/response codes and FSM encoding for the Ethernet DMA memory responder.
package iob_eth_axi_mem_slv_pkg;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WDATA  = 3'd1,
        ST_WRESP  = 3'd2,
        ST_RFIRST = 3'd3,
        ST_RDATA  = 3'd4
    } state_e;

    // WRAP and the reserved encoding are both refused
    function automatic logic burst_unsupported(input logic [1:0] burst);
        return burst[1];
    endfunction

endpackage

// File: rtl/iob_eth_axi_burst_addr.sv
// Burst address generator: latched word address, beat counter, INCR/FIXED stepping and last-beat flag.
module iob_eth_axi_burst_addr
    import iob_eth_axi_mem_slv_pkg::*;
#(
    parameter int MEM_ADDR_W = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [MEM_ADDR_W-1:0] load_addr,
    input  logic [7:0]            load_len,
    input  logic [1:0]            load_burst,
    input  logic                  step,
    output logic [MEM_ADDR_W-1:0] addr,
    output logic [MEM_ADDR_W-1:0] addr_next,
    output logic                  last
);

    logic [MEM_ADDR_W-1:0] addr_r;
    logic [MEM_ADDR_W-1:0] addr_next_s;
    logic [7:0]            cnt_r;
    logic [7:0]            len_r;
    logic [1:0]            burst_r;
    logic                  last_s;

    // Natural wrap of the word address; FIXED bursts keep hitting the same word
    assign addr_next_s = (burst_r == BURST_INCR) ? (addr_r + MEM_ADDR_W'(1)) : addr_r;
    assign last_s      = (cnt_r == len_r);

    assign addr      = addr_r;
    assign addr_next = addr_next_s;
    assign last      = last_s;

    // Burst context register: loaded on address handshake, advanced per beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r  <= '0;
            cnt_r   <= 8'd0;
            len_r   <= 8'd0;
            burst_r <= BURST_FIXED;
        end else if (load) begin
            addr_r  <= load_addr;
            cnt_r   <= 8'd0;
            len_r   <= load_len;
            burst_r <= load_burst;
        end else if (step) begin
            addr_r <= addr_next_s;
            // Counter saturates at len so a 256-beat burst never wraps it
            if (!last_s) begin
                cnt_r <= cnt_r + 8'd1;
            end
        end
    end

endmodule

// File: rtl/iob_eth_axi_mem_slv.sv
// AXI4 slave that serves the Ethernet DMA master's bursts from a single-port synchronous word RAM.
module iob_eth_axi_mem_slv
    import iob_eth_axi_mem_slv_pkg::*;
#(
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 32,
    parameter int AXI_ID_W   = 1,
    parameter int MEM_ADDR_W = 9
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [AXI_ID_W-1:0]     s_axi_awid,
    input  logic [AXI_ADDR_W-1:0]   s_axi_awaddr,
    input  logic [7:0]              s_axi_awlen,
    input  logic [2:0]              s_axi_awsize,
    input  logic [1:0]              s_axi_awburst,
    input  logic                    s_axi_awlock,
    input  logic [3:0]              s_axi_awcache,
    input  logic [2:0]              s_axi_awprot,
    input  logic [3:0]              s_axi_awqos,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [AXI_DATA_W-1:0]   s_axi_wdata,
    input  logic [AXI_DATA_W/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [AXI_ID_W-1:0]     s_axi_bid,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [AXI_ID_W-1:0]     s_axi_arid,
    input  logic [AXI_ADDR_W-1:0]   s_axi_araddr,
    input  logic [7:0]              s_axi_arlen,
    input  logic [2:0]              s_axi_arsize,
    input  logic [1:0]              s_axi_arburst,
    input  logic                    s_axi_arlock,
    input  logic [3:0]              s_axi_arcache,
    input  logic [2:0]              s_axi_arprot,
    input  logic [3:0]              s_axi_arqos,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [AXI_ID_W-1:0]     s_axi_rid,
    output logic [AXI_DATA_W-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    output logic                    mem_en,
    output logic [MEM_ADDR_W-1:0]   mem_addr,
    output logic [AXI_DATA_W/8-1:0] mem_we,
    output logic [AXI_DATA_W-1:0]   mem_wdata,
    input  logic [AXI_DATA_W-1:0]   mem_rdata
);

    localparam int S = $clog2(AXI_DATA_W / 8);

    state_e                state_r;
    logic [AXI_ID_W-1:0]   id_r;
    logic                  err_r;
    logic                  rdy_r;

    logic                  aw_hs_s;
    logic                  ar_hs_s;
    logic                  load_s;
    logic                  step_s;
    logic                  last_s;
    logic [MEM_ADDR_W-1:0] addr_s;
    logic [MEM_ADDR_W-1:0] addr_next_s;
    logic [MEM_ADDR_W-1:0] load_addr_s;
    logic [7:0]            load_len_s;
    logic [1:0]            load_burst_s;
    logic                  unused_s;

    assign unused_s = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos,
                        s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos};

    // Request is refused for a narrow size, an unsupported burst, or an address beyond the RAM
    function automatic logic req_err(input logic [AXI_ADDR_W-1:0] addr,
                                     input logic [2:0]            size,
                                     input logic [1:0]            burst);
        logic [AXI_ADDR_W-1:0] hi;
        hi = addr >> (MEM_ADDR_W + S);
        return (size != 3'(S)) || burst_unsupported(burst) || (hi != '0);
    endfunction

    // rdy_r is only ever set while idle, so it doubles as the IDLE qualifier; writes win ties
    assign aw_hs_s = rdy_r && s_axi_awvalid;
    assign ar_hs_s = rdy_r && !s_axi_awvalid && s_axi_arvalid;
    assign load_s  = aw_hs_s || ar_hs_s;

    // Select the address channel that feeds the burst generator
    always_comb begin
        load_addr_s  = s_axi_araddr[MEM_ADDR_W+S-1:S];
        load_len_s   = s_axi_arlen;
        load_burst_s = s_axi_arburst;
        if (s_axi_awvalid) begin
            load_addr_s  = s_axi_awaddr[MEM_ADDR_W+S-1:S];
            load_len_s   = s_axi_awlen;
            load_burst_s = s_axi_awburst;
        end else begin
            load_addr_s  = s_axi_araddr[MEM_ADDR_W+S-1:S];
            load_len_s   = s_axi_arlen;
            load_burst_s = s_axi_arburst;
        end
    end

    iob_eth_axi_burst_addr #(
        .MEM_ADDR_W (MEM_ADDR_W)
    ) u_burst_addr (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load_s),
        .load_addr  (load_addr_s),
        .load_len   (load_len_s),
        .load_burst (load_burst_s),
        .step       (step_s),
        .addr       (addr_s),
        .addr_next  (addr_next_s),
        .last       (last_s)
    );

    assign s_axi_awready = rdy_r;
    assign s_axi_arready = rdy_r && !s_axi_awvalid;
    assign s_axi_wready  = (state_r == ST_WDATA);
    assign s_axi_bvalid  = (state_r == ST_WRESP);
    assign s_axi_bid     = id_r;
    assign s_axi_bresp   = (s_axi_bvalid && err_r) ? RESP_SLVERR : RESP_OKAY;
    assign s_axi_rvalid  = (state_r == ST_RDATA);
    assign s_axi_rid     = id_r;
    assign s_axi_rdata   = (s_axi_rvalid && !err_r) ? mem_rdata : '0;
    assign s_axi_rresp   = (s_axi_rvalid && err_r) ? RESP_SLVERR : RESP_OKAY;
    assign s_axi_rlast   = s_axi_rvalid && last_s;

    // RAM port: writes land in the W handshake cycle; reads prefetch the next word on each R handshake
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = '0;
        mem_addr  = addr_s;
        mem_wdata = s_axi_wdata;
        step_s    = 1'b0;
        case (state_r)
            ST_WDATA: begin
                if (s_axi_wvalid) begin
                    mem_en = 1'b1;
                    mem_we = err_r ? '0 : s_axi_wstrb;
                    step_s = 1'b1;
                end else begin
                    mem_en = 1'b0;
                    step_s = 1'b0;
                end
            end
            ST_RFIRST: begin
                mem_en = 1'b1;
            end
            ST_RDATA: begin
                // Stalled beats leave the RAM idle so its output, and rdata, holds
                if (s_axi_rready && !last_s) begin
                    mem_en   = 1'b1;
                    mem_addr = addr_next_s;
                    step_s   = 1'b1;
                end else begin
                    mem_en   = 1'b0;
                    mem_addr = addr_s;
                    step_s   = 1'b0;
                end
            end
            default: begin
                mem_en = 1'b0;
            end
        endcase
    end

    // Transaction FSM with latched id/error and the registered idle-ready flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            id_r    <= '0;
            err_r   <= 1'b0;
            rdy_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (aw_hs_s) begin
                        id_r    <= s_axi_awid;
                        err_r   <= req_err(s_axi_awaddr, s_axi_awsize, s_axi_awburst);
                        rdy_r   <= 1'b0;
                        state_r <= ST_WDATA;
                    end else if (ar_hs_s) begin
                        id_r    <= s_axi_arid;
                        err_r   <= req_err(s_axi_araddr, s_axi_arsize, s_axi_arburst);
                        rdy_r   <= 1'b0;
                        state_r <= ST_RFIRST;
                    end else begin
                        rdy_r <= 1'b1;
                    end
                end
                ST_WDATA: begin
                    if (s_axi_wvalid) begin
                        if (s_axi_wlast != last_s) begin
                            err_r <= 1'b1;
                        end
                        if (last_s) begin
                            state_r <= ST_WRESP;
                        end
                    end
                end
                ST_WRESP: begin
                    if (s_axi_bready) begin
                        rdy_r   <= 1'b1;
                        state_r <= ST_IDLE;
                    end
                end
                ST_RFIRST: begin
                    state_r <= ST_RDATA;
                end
                ST_RDATA: begin
                    if (s_axi_rready && last_s) begin
                        rdy_r   <= 1'b1;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    rdy_r   <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
